// File: rtl/prog_loader_pkg.sv
// Shared types and defaults for the serial program loader.
// The CHECK state exists only when LOADER_CHECKSUM_EN is defined.
package prog_loader_pkg;

  localparam int DEF_CLKS_PER_BIT = 434;  // 50 MHz / 115200 baud
  localparam int DEF_MEM_WORDS    = 512;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA_HI,
    DATA_LO,
`ifdef LOADER_CHECKSUM_EN
    CHECK,
`endif
    DONE,
    ERROR
  } ld_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/prog_loader_uart_rx_byte.sv
// 8N1 byte receiver: two-flop synchroniser, falling-edge start detect with a
// mid-bit re-check, mid-bit data/stop sampling and a down-counting bit timer.
// rx_byte/byte_valid/frame_err are registered, so they appear one cycle after
// the stop-bit sample. start_det pulses when a start bit is confirmed.
module uart_rx_byte
  import prog_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err,
  output logic       start_det
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  rx_state_t     state, state_nxt;
  logic          rx_s1, rx_s2, rx_d;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          tc;
  logic          fall;

  assign tc   = (cnt == '0);
  assign fall = rx_d & ~rx_s2;

  // Synchronise the line and keep one extra delayed copy for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  // Receiver state register.
  always_ff @(posedge clk) begin
    if (rst) state <= RX_IDLE;
    else     state <= state_nxt;
  end

  // Next state: a start bit that is high again at mid-bit was a glitch.
  always_comb begin
    state_nxt = state;
    case (state)
      RX_IDLE:  if (fall) state_nxt = RX_START;
      RX_START: if (tc) state_nxt = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (tc && (bit_idx == 3'd7)) state_nxt = RX_STOP;
      RX_STOP:  if (tc) state_nxt = RX_IDLE;
      default:  state_nxt = RX_IDLE;
    endcase
  end

  // Bit timer, LSB-first shift register and registered byte outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      start_det  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      start_det  <= 1'b0;
      case (state)
        RX_IDLE: if (fall) cnt <= HALF;
        RX_START: begin
          if (tc) begin
            cnt       <= FULL;
            bit_idx   <= '0;
            start_det <= ~rx_s2;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RX_DATA: begin
          if (tc) begin
            cnt     <= FULL;
            shreg   <= {rx_s2, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RX_STOP: begin
          if (tc) begin
            if (rx_s2) rx_byte <= shreg;
            byte_valid <= rx_s2;
            frame_err  <= ~rx_s2;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Serial program loader: receives a length-prefixed frame of 16-bit words over
// UART, writes them into instruction memory from address 0, then releases the
// CPU. Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
//
// state   | meaning
// IDLE    | waiting for the first start bit
// LEN_HI  | expecting length high byte
// LEN_LO  | expecting length low byte, then range check of N
// DATA_HI | expecting high byte of the current word
// DATA_LO | expecting low byte, write the word
// CHECK   | expecting checksum byte (checksum build only)
// DONE    | load complete, cpu_run high, line ignored
// ERROR   | bad length, framing or checksum error, held until reset
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int MEM_WORDS    = DEF_MEM_WORDS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rx,
  output logic        mem_we,
  output logic [8:0]  mem_addr,
  output logic [15:0] mem_wdata,
  output logic        cpu_run,
  output logic        load_err
);

  localparam logic [15:0] MAX_LEN = 16'(MEM_WORDS);

  ld_state_t   state, state_nxt;
  logic [7:0]  rx_byte;
  logic        byte_valid, frame_err, start_det;
  logic [7:0]  len_hi, data_hi;
  logic [9:0]  n_words, word_idx;
  logic [15:0] len_full;
  logic        len_ok, last_word, wr_en;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rx         (uart_rx),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .frame_err  (frame_err),
    .start_det  (start_det)
  );

  assign len_full  = {len_hi, rx_byte};
  assign len_ok    = (len_full != 16'd0) && (len_full <= MAX_LEN);
  // Full 10-bit compare so that N=512 finishes at index 511 without wrapping.
  assign last_word = ((word_idx + 10'd1) == n_words);
  assign cpu_run   = (state == DONE);
  assign load_err  = (state == ERROR);

  // Loader state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Frame sequencing; DONE and ERROR are terminal until reset.
  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    case (state)
      IDLE: if (start_det) state_nxt = LEN_HI;
      LEN_HI: begin
        if (frame_err)       state_nxt = ERROR;
        else if (byte_valid) state_nxt = LEN_LO;
      end
      LEN_LO: begin
        if (frame_err)       state_nxt = ERROR;
        else if (byte_valid) state_nxt = len_ok ? DATA_HI : ERROR;
      end
      DATA_HI: begin
        if (frame_err)       state_nxt = ERROR;
        else if (byte_valid) state_nxt = DATA_LO;
      end
      DATA_LO: begin
        if (frame_err) begin
          state_nxt = ERROR;
        end else if (byte_valid) begin
          wr_en = 1'b1;
`ifdef LOADER_CHECKSUM_EN
          state_nxt = last_word ? CHECK : DATA_HI;
`else
          state_nxt = last_word ? DONE : DATA_HI;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: begin
        if (frame_err)       state_nxt = ERROR;
        else if (byte_valid) state_nxt = (rx_byte == csum) ? DONE : ERROR;
      end
`endif
      DONE:    state_nxt = DONE;
      ERROR:   state_nxt = ERROR;
      default: state_nxt = IDLE;
    endcase
  end

  // Frame datapath: length capture, word assembly and the write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      len_hi    <= '0;
      data_hi   <= '0;
      n_words   <= '0;
      word_idx  <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      mem_we <= wr_en;
      if (byte_valid) begin
        case (state)
          LEN_HI:  len_hi  <= rx_byte;
          LEN_LO:  n_words <= len_full[9:0];
          DATA_HI: data_hi <= rx_byte;
          default: ;
        endcase
      end
      if (wr_en) begin
        mem_addr  <= word_idx[8:0];
        mem_wdata <= {data_hi, rx_byte};
        word_idx  <= word_idx + 10'd1;
      end
`ifdef LOADER_CHECKSUM_EN
      if (byte_valid && (state inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO}))
        csum <= csum ^ rx_byte;
`endif
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader with a short bit time; works with and without
// LOADER_CHECKSUM_EN (frames gain a trailing checksum byte when defined).
module tb_prog_loader;

  localparam int CPB = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        uart_rx = 1'b1;
  logic        mem_we;
  logic [8:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        cpu_run;
  logic        load_err;

  int n_cmp = 0;
  int n_bad = 0;
  int wr_cnt = 0;
  logic [31:0] exp_q[$];
  logic [15:0] words_q[$];

  typedef struct {
    logic [15:0] len;
    int          nw;
    logic [15:0] w0;
    logic [15:0] w1;
    bit          run;
    bit          err;
  } vec_t;

  vec_t vecs[5];

  prog_loader #(.CLKS_PER_BIT(CPB), .MEM_WORDS(512)) dut (
    .clk       (clk),
    .rst       (rst),
    .uart_rx   (uart_rx),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_run   (cpu_run),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Write scoreboard: every strobe must match the next expected {addr,data}.
  always @(negedge clk) begin : mon
    logic [31:0] e;
    if (mem_we === 1'b1) begin
      wr_cnt++;
      if (exp_q.size() == 0) e = 32'hDEAD_BEEF;
      else                   e = exp_q.pop_front();
      check("write", {7'd0, mem_addr, mem_wdata}, e);
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit bad_stop = 1'b0);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = ~bad_stop;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
  endtask

  task automatic send_frame(input logic [15:0] len);
    logic [7:0] bq[$];
    bq.push_back(len[15:8]);
    bq.push_back(len[7:0]);
    foreach (words_q[i]) begin
      bq.push_back(words_q[i][15:8]);
      bq.push_back(words_q[i][7:0]);
    end
`ifdef LOADER_CHECKSUM_EN
    begin : csb
      logic [7:0] cs;
      cs = 8'h00;
      foreach (bq[i]) cs = cs ^ bq[i];
      bq.push_back(cs);
    end
`endif
    foreach (bq[i]) send_byte(bq[i]);
    repeat (4 * CPB) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_cpu_run", cpu_run, 0);
    check("rst_load_err", load_err, 0);
    rst = 1'b0;
    exp_q.delete();
    words_q.delete();
    wr_cnt = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic end_check(input string name, input bit run, input bit err, input int nwr);
    check({name, "_cpu_run"}, cpu_run, run);
    check({name, "_load_err"}, load_err, err);
    check({name, "_writes"}, wr_cnt, nwr);
    check({name, "_pending"}, exp_q.size(), 0);
  endtask

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{16'h0002, 2, 16'h1234, 16'hABCD, 1'b1, 1'b0};
    vecs[1] = '{16'h0000, 0, 16'h0000, 16'h0000, 1'b0, 1'b1};
    vecs[2] = '{16'h0201, 0, 16'h0000, 16'h0000, 1'b0, 1'b1};
    vecs[3] = '{16'h0001, 1, 16'h00FF, 16'h0000, 1'b1, 1'b0};
    vecs[4] = '{16'h1000, 0, 16'h0000, 16'h0000, 1'b0, 1'b1};

    for (int v = 0; v < 5; v++) begin
      do_reset();
      if (vecs[v].nw > 0) words_q.push_back(vecs[v].w0);
      if (vecs[v].nw > 1) words_q.push_back(vecs[v].w1);
      if (vecs[v].run) begin
        if (vecs[v].nw > 0) exp_q.push_back({7'd0, 9'd0, vecs[v].w0});
        if (vecs[v].nw > 1) exp_q.push_back({7'd0, 9'd1, vecs[v].w1});
      end
      send_frame(vecs[v].len);
      end_check($sformatf("vec%0d", v), vecs[v].run, vecs[v].err,
                vecs[v].run ? vecs[v].nw : 0);
      if (vecs[v].run) begin
        check($sformatf("vec%0d_hold_addr", v), mem_addr, vecs[v].nw - 1);
        check($sformatf("vec%0d_hold_data", v), mem_wdata,
              (vecs[v].nw > 1) ? vecs[v].w1 : vecs[v].w0);
      end
    end

    // DONE ignores a second frame on the line.
    do_reset();
    words_q.push_back(16'hBEEF);
    exp_q.push_back({7'd0, 9'd0, 16'hBEEF});
    send_frame(16'h0001);
    words_q.delete();
    words_q.push_back(16'h1111);
    send_frame(16'h0001);
    end_check("done_ignore", 1'b1, 1'b0, 1);
    check("done_hold_data", mem_wdata, 16'hBEEF);

    // Full-depth frame: 512 words, last at address 511.
    do_reset();
    for (int i = 0; i < 512; i++) begin
      logic [15:0] w;
      w = 16'(i * 3 + 7) ^ 16'hA5C3;
      words_q.push_back(w);
      exp_q.push_back({7'd0, 9'(i), w});
    end
    send_frame(16'h0200);
    end_check("n512", 1'b1, 1'b0, 512);
    check("n512_last_addr", mem_addr, 9'd511);

    // Framing error on the first byte; a later good frame stays ignored.
    do_reset();
    send_byte(8'h00, 1'b1);
    repeat (4 * CPB) @(negedge clk);
    end_check("frame_err", 1'b0, 1'b1, 0);
    words_q.push_back(16'h4242);
    send_frame(16'h0001);
    end_check("frame_err_held", 1'b0, 1'b1, 0);

    // 0.4-bit low glitch on idle must not start a byte.
    do_reset();
    uart_rx = 1'b0;
    repeat (2) @(negedge clk);
    uart_rx = 1'b1;
    repeat (20 * CPB) @(negedge clk);
    end_check("glitch_idle", 1'b0, 1'b0, 0);
    words_q.push_back(16'h5AC3);
    exp_q.push_back({7'd0, 9'd0, 16'h5AC3});
    send_frame(16'h0001);
    end_check("glitch_then_frame", 1'b1, 1'b0, 1);

    // Reset in the middle of the second data byte, then a clean frame.
    do_reset();
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h12);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      uart_rx = (i % 2 == 0);
      repeat (CPB) @(negedge clk);
    end
    do_reset();
    repeat (10 * CPB) @(negedge clk);
    end_check("mid_rst", 1'b0, 1'b0, 0);
    words_q.push_back(16'hC0DE);
    exp_q.push_back({7'd0, 9'd0, 16'hC0DE});
    send_frame(16'h0001);
    end_check("after_rst", 1'b1, 1'b0, 1);
    check("after_rst_addr", mem_addr, 9'd0);

`ifdef LOADER_CHECKSUM_EN
    // 0x00^0x01^0x00^0xFF = 0xFE; word is written before the checksum verdict.
    do_reset();
    exp_q.push_back({7'd0, 9'd0, 16'h00FF});
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h00); send_byte(8'hFF);
    send_byte(8'h01);
    repeat (4 * CPB) @(negedge clk);
    end_check("csum_bad", 1'b0, 1'b1, 1);
    do_reset();
    exp_q.push_back({7'd0, 9'd0, 16'h00FF});
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h00); send_byte(8'hFF);
    send_byte(8'hFE);
    repeat (4 * CPB) @(negedge clk);
    end_check("csum_good", 1'b1, 1'b0, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, meaning clk cycles per UART bit (50 MHz / 115200 baud).
REQ-002 SHALL have parameter MEM_WORDS, default 512, meaning instruction memory depth in 16-bit words.
REQ-003 SHALL have port clk  input  1  system clock; all logic is on posedge clk.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port uart_rx  input  1  asynchronous serial line, 8N1, idle high.
REQ-006 SHALL have port mem_we  output  1  one-cycle write strobe to the CPU instruction memory.
REQ-007 SHALL have port mem_addr  output  9  word address for the write.
REQ-008 SHALL have port mem_wdata  output  16  word to be written.
REQ-009 SHALL have port cpu_run  output  1  high only after a load completes successfully; the CPU holds in FETCH while it is low.
REQ-010 SHALL have port load_err  output  1  sticky error flag.

Function
REQ-011 SHALL synchronise uart_rx through two flip-flops before any use.
REQ-012 SHALL detect a start bit on a high-to-low edge, re-check it low at CLKS_PER_BIT/2, and otherwise return to line idle.
REQ-013 SHALL sample the 8 data bits, LSB first, at mid-bit; the stop bit SHALL be sampled at mid-bit.
REQ-014 SHALL discard a byte with a low stop bit (framing error), set load_err, and enter ERROR.
REQ-015 SHALL produce a one-cycle byte_valid pulse per good byte, one cycle after the stop-bit sample.
REQ-016 SHALL accept the frame format: length hi, length lo, then N words sent hi byte then lo byte, then an optional checksum byte (REQ-028).
REQ-017 SHALL implement the states IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK, DONE, ERROR.
REQ-018 SHALL move IDLE->LEN_HI when the first start bit is detected; LEN_HI->LEN_LO->DATA_HI on each byte_valid.
REQ-019 SHALL enter ERROR if N is 0 or greater than MEM_WORDS.
REQ-020 SHALL alternate DATA_HI->DATA_LO->DATA_HI; on each DATA_LO byte it SHALL assert mem_we for exactly one cycle with mem_wdata={hi,lo} and mem_addr = word index (first word at address 0).
REQ-021 SHALL increment the word index after each write; after word N-1 it SHALL go to CHECK if the checksum is enabled, else to DONE.
REQ-022 SHALL hold cpu_run high in DONE, ignore further uart_rx traffic, and assert no further mem_we until reset.
REQ-023 SHALL keep cpu_run low and mem_we low in ERROR, which is held until reset.
REQ-024 SHALL hold mem_addr and mem_wdata stable from the mem_we cycle until the next write.
REQ-025 SHALL compare the word index against N at the full 10 bits so that N=512 ends at address 511 without wrapping.

Reset
REQ-026 SHALL on rst set state=IDLE, mem_we=0, mem_addr=0, mem_wdata=0, cpu_run=0, load_err=0, word index=0, checksum=0, receiver idle, synchronisers=1.
REQ-027 SHALL abort a reset asserted mid-byte or mid-frame with no partial write; the next frame SHALL restart at address 0.

Configuration
REQ-028 SHALL compile a running XOR checksum of all length and data bytes when LOADER_CHECKSUM_EN is defined; the CHECK state SHALL compare it with the received byte, going to DONE on a match and to ERROR with load_err=1 on a mismatch.
REQ-029 SHALL omit the CHECK state and the checksum register when LOADER_CHECKSUM_EN is undefined; the frame then has no trailing byte.

Structure
REQ-030 SHALL place the state enumeration, the MEM_WORDS default and CLKS_PER_BIT default in the shared package prog_loader_pkg.
REQ-031 SHALL implement the serial byte receiver (REQ-011..015) as the sub-module uart_rx_byte, outputting byte[7:0], byte_valid and frame_err.

Verification
REQ-032 SHALL be tested as follows: frame N=2, words 0x1234, 0xABCD -> mem_we pulses at addr 0 (0x1234) and addr 1 (0xABCD), then cpu_run=1.
REQ-033 SHALL be tested as follows: with LOADER_CHECKSUM_EN and N=1, word 0x00FF, checksum 0x01 (0x00^0x01^0x00^0xFF=0xFE, mismatch) -> load_err=1 and cpu_run=0; with checksum 0xFE -> cpu_run=1.
REQ-034 SHALL be tested as follows: length 0x0000 or 0x0201 -> ERROR, no mem_we, load_err=1.
REQ-035 SHALL be tested as follows: N=512 -> last write at addr 511, exactly 512 mem_we pulses, cpu_run=1.
REQ-036 SHALL be tested as follows: a byte with its stop bit forced low -> load_err=1; a 0.4-bit low glitch on idle -> no byte accepted.
REQ-037 SHALL be tested as follows: rst asserted during the second data byte -> outputs at reset values; a full N=1 frame afterwards writes addr 0.
